// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic datapath blocks.
package arith_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int SLICE_DEF  = 4;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit4_sub_slice.sv
// One slice of the serial subtractor: s = a + b_n + c with carry out.
// The caller supplies the subtrahend already inverted, so borrow = ~co.
module bit4_sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b_n,
  input  logic             c,
  output logic [SLICE-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b_n} + {{SLICE{1'b0}}, c};

endmodule

// File: rtl/bit32_serial_sub.sv
// Multi-cycle unsigned subtractor: A - B - Bin computed one slice per
// clock, LSB slice first, with a start/ready/done handshake.
module bit32_serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             c;
  logic [SLICE-1:0] s;
  logic             co;
  logic [WIDTH-1:0] rd_next;
  logic             accept;

  // Handshake outputs are pure state decodes, so nothing from start/A/B
  // reaches them combinationally.
  assign ready  = (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = ready && start;

  bit4_sub_slice #(.SLICE(SLICE)) u_slice (
    .a   (ra[SLICE-1:0]),
    .b_n (rb[SLICE-1:0]),
    .c   (c),
    .s   (s),
    .co  (co)
  );

  // New slice enters at the top so slice k lands at bits [4k+3:4k].
  assign rd_next = {s, rd[WIDTH-1:SLICE]};

  // Control FSM and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            Diff  <= rd_next;
            Bout  <= ~co;
            Zero  <= (rd_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shift registers: load on acceptance (subtrahend and borrow
  // inverted), then consume one slice per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra <= A;
      rb <= ~B;
      c  <= ~Bin;
    end else if (state == RUN) begin
      ra <= ra >> SLICE;
      rb <= rb >> SLICE;
      rd <= rd_next;
      c  <= co;
    end
  end

endmodule
